gesture_frame_ctrl: RTL and testbench
=====================================

GESTURE_FRAME_CTRL -- requirements
Module: gesture_frame_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter IMG_H, default 480, meaning active lines per frame.
REQ-003 SHALL have parameters ROI_X0/ROI_X1/ROI_Y0/ROI_Y1, defaults 0/639/0/479, meaning the inclusive counting window.
REQ-004 SHALL have parameters T0..T6, defaults 100/10000/20000/30000/40000/50000/60000, meaning the class bin thresholds.
REQ-005 SHALL have parameter STABLE_N, default 3, range 1..15, meaning the consecutive equal frames required before the led output changes.
REQ-006 SHALL have the ports:
- clk  in  1  pixel clock; single clock domain; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run request.
- per_frame_clken  in  1  pixel-valid strobe.
- per_img_Bit  in  1  binarised pixel; 1 = hand.
- xpos  in  10  pixel column.
- ypos  in  10  pixel row.
- led  out  3  filtered gesture class.
- result_valid  out  1  one-cycle pulse per classified frame.
- led_update  out  1  one-cycle pulse when led changes.
- frame_abort  out  1  one-cycle pulse when a frame is truncated.
- busy  out  1  high in any state other than IDLE.

Function
REQ-007 SHALL decode SOF as per_frame_clken & xpos==0 & ypos==0, and EOF as per_frame_clken & xpos==IMG_W-1 & ypos==IMG_H-1.
REQ-008 SHALL implement FSM states IDLE, WAIT_SOF, COUNT, CLASSIFY and FILTER.
REQ-009 SHALL make these transitions:
- IDLE->WAIT_SOF when enable=1.
- WAIT_SOF->COUNT on SOF.
- COUNT->CLASSIFY on EOF.
- CLASSIFY->FILTER unconditionally.
- FILTER->WAIT_SOF unconditionally.
REQ-010 SHALL move from any state to IDLE on the cycle after enable=0; in-progress counts are discarded and led holds its value.
REQ-011 SHALL clear hand_cnt (17 bit) on the SOF cycle and load it with 1 if that SOF pixel qualifies.
REQ-012 SHALL, in COUNT, increment hand_cnt on cycles with per_frame_clken=1, per_img_Bit=1 and xpos/ypos inside the ROI (inclusive); the EOF pixel is included.
REQ-013 SHALL saturate hand_cnt at 131071 with no wrap.
REQ-014 SHALL, on an SOF in COUNT with no preceding EOF, pulse frame_abort, restart the count from that SOF and stay in COUNT.
REQ-015 SHALL ignore SOF while in CLASSIFY or FILTER, so that frame is skipped.
REQ-016 SHALL, in CLASSIFY, register class from hand_cnt as:
- <=T0 gives 000.
- <T1 gives 111.
- <T2 gives 001.
- <T3 gives 010.
- <T4 gives 011.
- <T5 gives 100.
- <T6 gives 101.
- otherwise gives 110.
REQ-017 SHALL, in FILTER when class equals the candidate register, increment match_cnt, saturating at STABLE_N.
REQ-018 SHALL, in FILTER when class differs from the candidate register, load candidate=class and match_cnt=1.
REQ-019 SHALL, in FILTER, load led<=candidate' (the updated candidate) when the updated match_cnt equals STABLE_N and candidate' differs from led; led_update pulses in the same cycle.
REQ-020 SHALL pulse result_valid in the FILTER cycle of every classified frame.
REQ-021 SHALL give a latency of EOF at cycle t -> CLASSIFY at t+1 -> FILTER at t+2; led, led_update and result_valid register at the end of t+2 and are visible from t+3.
REQ-022 SHALL, with STABLE_N=1, update led on every classified frame whose class differs from led.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, set: state=IDLE, hand_cnt=0, candidate=000, match_cnt=0, led=000, result_valid=0, led_update=0, frame_abort=0, busy=0.
REQ-024 SHALL give rst priority over every other input, including mid-frame; after release a new frame starts only on the next SOF.

Verification
REQ-025 SHALL cover enable=1 with a 640x480 frame of 25000 ones and STABLE_N=3: result_valid pulses 3 times at frames 1-3, and after frame 3 led=010 with one led_update pulse.
REQ-026 SHALL cover frames with counts 25000, 25000, 45000, 25000: led stays 000 throughout because the candidate resets on the 45000 frame.
REQ-027 SHALL cover an all-zero frame followed by a 60000-pixel frame with STABLE_N=1: led=000 with no led_update, then led=110 with one led_update.
REQ-028 SHALL cover a second SOF issued at line 200 of a frame: frame_abort pulses once, the next EOF classifies only the pixels after the restart, and result_valid pulses once.
REQ-029 SHALL cover an all-ones frame: hand_cnt saturates at 131071, with no wrap to a small count, and class=110.
REQ-030 SHALL cover rst=1 asserted at line 300 of frame 2 while led=010: the next cycle shows led=000, busy=0 and state=IDLE.

Source files
------------

// File: rtl/gesture_frame_ctrl.sv
// Gesture frame controller: counts ROI hand pixels per frame, bins the count into
// a gesture class and debounces it over STABLE_N consecutive frames onto led.
module gesture_frame_ctrl #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int ROI_X0   = 0,
  parameter int ROI_X1   = 639,
  parameter int ROI_Y0   = 0,
  parameter int ROI_Y1   = 479,
  parameter int T0       = 100,
  parameter int T1       = 10000,
  parameter int T2       = 20000,
  parameter int T3       = 30000,
  parameter int T4       = 40000,
  parameter int T5       = 50000,
  parameter int T6       = 60000,
  parameter int STABLE_N = 3,
  parameter int CNT_W    = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       per_frame_clken,
  input  logic       per_img_Bit,
  input  logic [9:0] xpos,
  input  logic [9:0] ypos,
  output logic [2:0] led,
  output logic       result_valid,
  output logic       led_update,
  output logic       frame_abort,
  output logic       busy,
  output logic [2:0] dbg_state_o
);

  // Handshake: per_frame_clken qualifies xpos/ypos/per_img_Bit on the same cycle;
  // there is no back-pressure, every strobed pixel is consumed. Output pulses last
  // exactly one cycle.

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_SOF = 3'd1,
    S_COUNT    = 3'd2,
    S_CLASSIFY = 3'd3,
    S_FILTER   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [3:0]       STABLE_M = 4'(STABLE_N);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       class_q, class_d;
  logic [2:0]       cand_q, cand_d;
  logic [3:0]       match_q, match_d;
  logic [2:0]       led_q, led_d;
  logic             rv_q, rv_d;
  logic             lu_q, lu_d;
  logic             fa_q, fa_d;

  int   px, py;
  logic sof, eof, in_roi, qual;
  logic [2:0] cand_n;
  logic [3:0] match_n;

  assign px     = int'(xpos);
  assign py     = int'(ypos);
  assign sof    = per_frame_clken && (px == 0) && (py == 0);
  assign eof    = per_frame_clken && (px == IMG_W - 1) && (py == IMG_H - 1);
  assign in_roi = (px >= ROI_X0) && (px <= ROI_X1) && (py >= ROI_Y0) && (py <= ROI_Y1);
  assign qual   = per_frame_clken && per_img_Bit && in_roi;

  function automatic logic [2:0] classify(input logic [CNT_W-1:0] c);
    int v;
    v = int'(c);
    if (v <= T0)     return 3'b000;
    else if (v < T1) return 3'b111;
    else if (v < T2) return 3'b001;
    else if (v < T3) return 3'b010;
    else if (v < T4) return 3'b011;
    else if (v < T5) return 3'b100;
    else if (v < T6) return 3'b101;
    else             return 3'b110;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    class_d = class_q;
    cand_d  = cand_q;
    match_d = match_q;
    led_d   = led_q;
    rv_d    = 1'b0;
    lu_d    = 1'b0;
    fa_d    = 1'b0;
    cand_n  = cand_q;
    match_n = match_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_WAIT_SOF;
        S_WAIT_SOF: begin
          if (sof) begin
            state_d = S_COUNT;
            cnt_d   = {{(CNT_W-1){1'b0}}, qual};
          end
        end
        S_COUNT: begin
          // A fresh SOF before EOF means the previous frame was truncated.
          if (sof) begin
            fa_d  = 1'b1;
            cnt_d = {{(CNT_W-1){1'b0}}, qual};
          end else begin
            if (qual && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
            if (eof) state_d = S_CLASSIFY;
          end
        end
        S_CLASSIFY: begin
          class_d = classify(cnt_q);
          state_d = S_FILTER;
        end
        S_FILTER: begin
          if (class_q == cand_q) begin
            match_n = (match_q >= STABLE_M) ? STABLE_M : match_q + 4'd1;
          end else begin
            cand_n  = class_q;
            match_n = 4'd1;
          end
          cand_d  = cand_n;
          match_d = match_n;
          if ((match_n == STABLE_M) && (cand_n != led_q)) begin
            led_d = cand_n;
            lu_d  = 1'b1;
          end
          rv_d    = 1'b1;
          state_d = S_WAIT_SOF;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      class_q <= 3'b000;
      cand_q  <= 3'b000;
      match_q <= 4'd0;
      led_q   <= 3'b000;
      rv_q    <= 1'b0;
      lu_q    <= 1'b0;
      fa_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      class_q <= class_d;
      cand_q  <= cand_d;
      match_q <= match_d;
      led_q   <= led_d;
      rv_q    <= rv_d;
      lu_q    <= lu_d;
      fa_q    <= fa_d;
    end
  end

  assign led          = led_q;
  assign result_valid = rv_q;
  assign led_update   = lu_q;
  assign frame_abort  = fa_q;
  assign busy         = (state_q != S_IDLE);
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_gesture_frame_ctrl.sv
// Bench for gesture_frame_ctrl: two instances (STABLE_N=3 and STABLE_N=1, different
// ROIs) share one small-frame pixel stream and are checked against a frame-level model.
module tb_gesture_frame_ctrl;

  localparam int W = 32;
  localparam int H = 24;
  localparam int T0 = 10, T1 = 100, T2 = 200, T3 = 300, T4 = 350, T5 = 400, T6 = 450;
  localparam int CW = 9;
  localparam int CMAX = 511;
  // Instance 0: ROI x 0..29, y 0..22 (SOF inside). Instance 1: full frame (EOF inside).
  localparam int R0X1 = 29, R0Y1 = 22;

  logic clk = 1'b0;
  logic rst, enable, clken, bitv;
  logic [9:0] xpos, ypos;
  logic [2:0] led3, led1, st3, st1;
  logic rv3, rv1, lu3, lu1, fa3, fa1, busy3, busy1;

  always #5 clk = ~clk;

  gesture_frame_ctrl #(
    .IMG_W(W), .IMG_H(H), .ROI_X0(0), .ROI_X1(R0X1), .ROI_Y0(0), .ROI_Y1(R0Y1),
    .T0(T0), .T1(T1), .T2(T2), .T3(T3), .T4(T4), .T5(T5), .T6(T6),
    .STABLE_N(3), .CNT_W(CW)
  ) dut3 (
    .clk(clk), .rst(rst), .enable(enable), .per_frame_clken(clken), .per_img_Bit(bitv),
    .xpos(xpos), .ypos(ypos), .led(led3), .result_valid(rv3), .led_update(lu3),
    .frame_abort(fa3), .busy(busy3), .dbg_state_o(st3)
  );

  gesture_frame_ctrl #(
    .IMG_W(W), .IMG_H(H), .ROI_X0(0), .ROI_X1(W-1), .ROI_Y0(0), .ROI_Y1(H-1),
    .T0(T0), .T1(T1), .T2(T2), .T3(T3), .T4(T4), .T5(T5), .T6(T6),
    .STABLE_N(1), .CNT_W(CW)
  ) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .per_frame_clken(clken), .per_img_Bit(bitv),
    .xpos(xpos), .ypos(ypos), .led(led1), .result_valid(rv1), .led_update(lu1),
    .frame_abort(fa1), .busy(busy1), .dbg_state_o(st1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] exp_q3[$];
  logic [3:0] exp_q1[$];
  int  m_cnt[2], m_cand[2], m_run[2], m_led[2], exp_lu[2];
  int  exp_rv = 0, exp_fa = 0;
  bit  m_counting = 0;
  int  ns[2] = '{3, 1};
  int  bnd[17] = '{0, T0, T0+1, T1-1, T1, T2-1, T2, T3-1, T3, T4-1, T4, T5-1, T5, T6-1, T6, CMAX, 690};

  function automatic bit in_roi(input int i, input int x, input int y);
    if (i == 0) return (x <= R0X1) && (y <= R0Y1);
    return 1'b1;
  endfunction

  function automatic int ref_class(input int c);
    if (c <= T0) return 0;
    if (c < T1)  return 7;
    if (c < T2)  return 1;
    if (c < T3)  return 2;
    if (c < T4)  return 3;
    if (c < T5)  return 4;
    if (c < T6)  return 5;
    return 6;
  endfunction

  task automatic model_result(input int i, input int cls);
    bit upd;
    if (cls == m_cand[i]) begin
      if (m_run[i] < ns[i]) m_run[i]++;
    end else begin
      m_cand[i] = cls;
      m_run[i]  = 1;
    end
    upd = (m_run[i] == ns[i]) && (m_cand[i] != m_led[i]);
    if (upd) begin
      m_led[i] = m_cand[i];
      exp_lu[i]++;
    end
    if (i == 0) exp_q3.push_back({upd, 3'(m_led[i])});
    else        exp_q1.push_back({upd, 3'(m_led[i])});
  endtask

  task automatic model_pixel(input int x, input int y, input bit b);
    if (x == 0 && y == 0) begin
      if (m_counting) exp_fa++;
      m_counting = 1;
      m_cnt[0] = 0;
      m_cnt[1] = 0;
    end
    if (m_counting) begin
      for (int i = 0; i < 2; i++)
        if (b && in_roi(i, x, y) && m_cnt[i] < CMAX) m_cnt[i]++;
      if (x == W-1 && y == H-1) begin
        m_counting = 0;
        exp_rv++;
        for (int i = 0; i < 2; i++) model_result(i, ref_class(m_cnt[i]));
      end
    end
  endtask

  task automatic model_reset();
    m_counting = 0;
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_cand[i] = 0; m_run[i] = 0; m_led[i] = 0;
    end
    exp_q3.delete();
    exp_q1.delete();
  endtask

  // ---------------- scoreboard monitor ----------------
  int rv3_n = 0, rv1_n = 0, lu3_n = 0, lu1_n = 0, fa3_n = 0, fa1_n = 0;
  logic [3:0] e3, e1;

  always @(negedge clk) begin
    if (rv3) begin
      rv3_n++;
      if (exp_q3.size() == 0) check("rv3_unexpected", 1, 0);
      else begin
        e3 = exp_q3.pop_front();
        check("led3", int'(led3), int'(e3[2:0]));
        check("upd3", int'(lu3), int'(e3[3]));
      end
    end
    if (rv1) begin
      rv1_n++;
      if (exp_q1.size() == 0) check("rv1_unexpected", 1, 0);
      else begin
        e1 = exp_q1.pop_front();
        check("led1", int'(led1), int'(e1[2:0]));
        check("upd1", int'(lu1), int'(e1[3]));
      end
    end
    if (lu3) lu3_n++;
    if (lu1) lu1_n++;
    if (fa3) fa3_n++;
    if (fa1) fa1_n++;
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      clken = 1'b0;
    end
  endtask

  task automatic drive_pix(input int x, input int y, input bit b);
    if ($urandom_range(0, 7) == 0) begin
      @(posedge clk); #1;
      clken = 1'b0;
      xpos  = 10'($urandom_range(0, 1023));
      ypos  = 10'($urandom_range(0, 1023));
      bitv  = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    clken = 1'b1;
    xpos  = 10'(x);
    ypos  = 10'(y);
    bitv  = b;
    model_pixel(x, y, b);
  endtask

  task automatic check_rst_state(input string tag);
    check({tag, "_led3"}, int'(led3), 0);
    check({tag, "_led1"}, int'(led1), 0);
    check({tag, "_busy3"}, int'(busy3), 0);
    check({tag, "_busy1"}, int'(busy1), 0);
    check({tag, "_state3"}, int'(st3), 0);
    check({tag, "_pulses"}, int'({rv3, lu3, fa3, rv1, lu1, fa1}), 0);
  endtask

  // target<0: random density; else the first target pixels of instance-0 ROI are 1.
  // action at (stop_row,0): 1 truncate, 2 reset pulse, 3 enable drop.
  task automatic drive_frame(input int target, input int stop_row, input int action);
    int pct, ridx;
    bit b;
    pct  = $urandom_range(0, 100);
    ridx = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (y == stop_row && x == 0) begin
          if (action == 1) return;
          if (action == 2) begin
            @(posedge clk); #1;
            clken = 1'b0;
            rst   = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check_rst_state("midframe_rst");
            model_reset();
          end
          if (action == 3) begin
            @(posedge clk); #1;
            clken  = 1'b0;
            enable = 1'b0;
            @(posedge clk); #1;
            check("en_drop_busy3", int'(busy3), 0);
            check("en_drop_state1", int'(st1), 0);
            enable = 1'b1;
            m_counting = 0;
          end
        end
        if (target < 0) b = ($urandom_range(1, 100) <= pct);
        else if (in_roi(0, x, y)) begin
          b = (ridx < target);
          ridx++;
        end else b = 1'b0;
        drive_pix(x, y, b);
      end
    end
    idle($urandom_range(4, 8));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    clken = 1'b0;
    rst   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    idle(3);
  endtask

  task automatic section(input string tag);
    int k;
    k = 0;
    while ((exp_q3.size() != 0 || exp_q1.size() != 0) && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_drain"}, exp_q3.size() + exp_q1.size(), 0);
    check({tag, "_rv3"}, rv3_n, exp_rv);
    check({tag, "_rv1"}, rv1_n, exp_rv);
    check({tag, "_lu3"}, lu3_n, exp_lu[0]);
    check({tag, "_lu1"}, lu1_n, exp_lu[1]);
    check({tag, "_fa3"}, fa3_n, exp_fa);
    check({tag, "_fa1"}, fa1_n, exp_fa);
    check({tag, "_led3_end"}, int'(led3), m_led[0]);
    check({tag, "_led1_end"}, int'(led1), m_led[1]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, tgt;
    rst = 1'b1; enable = 1'b0; clken = 1'b0; bitv = 1'b0; xpos = '0; ypos = '0;
    exp_lu[0] = 0; exp_lu[1] = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_rst_state("reset");
    rst = 1'b0;
    idle(3);
    check("no_enable_busy", int'(busy3), 0);
    enable = 1'b1;
    @(posedge clk); #1;
    check("wait_sof_state", int'(st3), 1);
    check("wait_sof_busy", int'(busy1), 1);

    repeat (3) drive_frame(250, -1, 0);
    section("stable3");
    check("stable3_led", int'(led3), 2);

    do_reset();
    drive_frame(250, -1, 0);
    drive_frame(250, -1, 0);
    drive_frame(375, -1, 0);
    drive_frame(250, -1, 0);
    section("cand_reset");
    check("cand_reset_led", int'(led3), 0);

    do_reset();
    drive_frame(0, -1, 0);
    check("zero_frame_led1", int'(led1), 0);
    drive_frame(500, -1, 0);
    section("stable1");
    check("stable1_led", int'(led1), 6);

    do_reset();
    drive_frame(-1, 12, 1);
    drive_frame(250, -1, 0);
    section("abort");

    do_reset();
    drive_frame(690, -1, 0);
    section("saturate");
    check("saturate_led1", int'(led1), 6);

    for (int n = 0; n < 16; n++) begin
      sel = $urandom_range(0, 9);
      tgt = (sel < 6) ? bnd[$urandom_range(0, 16)] : -1;
      if (sel == 9) drive_frame(tgt, $urandom_range(1, H-2), 3);
      else          drive_frame(tgt, -1, 0);
    end
    section("random");

    do_reset();
    repeat (3) drive_frame(250, -1, 0);
    check("pre_rst_led3", int'(led3), 2);
    drive_frame(250, 15, 2);
    drive_frame(250, -1, 0);
    section("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
